// File: rtl/cdc_event_scheduler.sv
// Round-robin scheduler that shares one toggle-synchronizer CDC channel among
// N_REQ event sources, spacing pulses GAP_CYCLES apart and flagging lost events.
module cdc_event_scheduler #(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 32,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             en_i,
    input  logic             clr_drop_i,
    output logic             pulse_o,
    output logic [ID_W-1:0]  id_o,
    output logic             busy_o,
    output logic [N_REQ-1:0] pending_o,
    output logic [N_REQ-1:0] drop_o
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_d;
    logic               pulse_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [N_REQ-1:0]   drop_q, drop_d;
    logic [N_REQ-1:0]   grant_mask;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               can_grant;
    logic               grant;
    int                 idx_i;

    // Rotating priority search: first pending requester at or after rr_q.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx_i  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_i = int'(rr_q) + i;
            if (idx_i >= N_REQ) idx_i = idx_i - N_REQ;
            if (!found && pending_q[ID_W'(idx_i)]) begin
                found  = 1'b1;
                winner = ID_W'(idx_i);
            end
        end
    end

    // The last busy cycle of a gap may grant again, keeping pulses exactly GAP_CYCLES apart.
    assign can_grant = (state_q == IDLE) || (cnt_q == CNT_W'(GAP_CYCLES));
    assign grant     = can_grant && en_i && found;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        id_d       = id_o;
        pulse_d    = 1'b0;
        grant_mask = '0;

        if (grant) begin
            state_d            = GAP;
            cnt_d              = CNT_W'(1);
            pulse_d            = 1'b1;
            id_d               = winner;
            grant_mask[winner] = 1'b1;
            rr_d               = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end else if (state_q == GAP) begin
            if (cnt_q == CNT_W'(GAP_CYCLES)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A request landing on the grant cycle is a fresh event, not an overflow.
        pending_d = (pending_q & ~grant_mask) | req_i;
        drop_d    = (clr_drop_i ? '0 : drop_q) | (req_i & pending_q & ~grant_mask);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_q      <= '0;
            id_o      <= '0;
            pulse_o   <= 1'b0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            id_o      <= id_d;
            pulse_o   <= pulse_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    assign busy_o    = (state_q == GAP);
    assign pending_o = pending_q;
    assign drop_o    = drop_q;

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Self-checking bench for cdc_event_scheduler: vector table, directed corner
// sequences and randomized traffic against a time-based reference model.
module tb_cdc_event_scheduler;

    localparam int N   = 4;
    localparam int GAP = 8;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          en;
    logic          clr;
    logic          pulse;
    logic [IW-1:0] id;
    logic          busy;
    logic [N-1:0]  pend;
    logic [N-1:0]  drop;

    int total = 0;
    int bad   = 0;

    cdc_event_scheduler #(
        .N_REQ      (N),
        .GAP_CYCLES (GAP),
        .ID_W       (IW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .en_i       (en),
        .clr_drop_i (clr),
        .pulse_o    (pulse),
        .id_o       (id),
        .busy_o     (busy),
        .pending_o  (pend),
        .drop_o     (drop)
    );

    always #5 clk = ~clk;

    // Reference model: channel occupancy derived from the time of the last pulse.
    int           m_t    = 0;
    int           m_last = -1000;
    int           m_id   = 0;
    int           m_ptr  = 0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_drop = '0;

    typedef struct {
        logic [N-1:0]  req;
        logic          en;
        logic          clr;
        logic          exp_pulse;
        logic [IW-1:0] exp_id;
        logic          exp_busy;
        logic [N-1:0]  exp_pend;
        logic [N-1:0]  exp_drop;
    } vec_t;

    vec_t tbl[12];
    int   pc[$];
    int   pid[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, m_t, act, exp);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic e, input logic c, input logic rs);
        logic [N-1:0]  gm;
        logic [IW-1:0] wi;
        int            w;
        gm = '0;
        if (rs) begin
            m_pend = '0;
            m_drop = '0;
            m_id   = 0;
            m_ptr  = 0;
            m_last = -1000;
        end else begin
            if (e && m_pend != '0 && (m_t + 1 - m_last) >= GAP) begin
                for (int k = 0; k < N; k++) begin
                    w  = (m_ptr + k) % N;
                    wi = IW'(w);
                    if (gm == '0 && m_pend[wi]) begin
                        gm[wi] = 1'b1;
                        m_id   = w;
                    end
                end
                m_ptr  = (m_id + 1) % N;
                m_last = m_t + 1;
            end
            m_drop = (c ? '0 : m_drop) | (r & m_pend & ~gm);
            m_pend = (m_pend & ~gm) | r;
        end
        m_t++;
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic e, input logic c, input logic rs);
        req = r;
        en  = e;
        clr = c;
        rst = rs;
        model_edge(r, e, c, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle('0, 1'b0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_vs_model();
        check("rnd_pulse", int'(pulse), int'(m_t == m_last));
        check("rnd_id",    int'(id),    m_id);
        check("rnd_busy",  int'(busy),  int'(m_t >= m_last && (m_t - m_last) < GAP));
        check("rnd_pend",  int'(pend),  int'(m_pend));
        check("rnd_drop",  int'(drop),  int'(m_drop));
    endtask

    function automatic vec_t mk(input logic [N-1:0] r, input logic e, input logic p,
                                input logic [IW-1:0] i, input logic b,
                                input logic [N-1:0] pd, input logic [N-1:0] dr);
        vec_t v;
        v.req = r; v.en = e; v.clr = 1'b0;
        v.exp_pulse = p; v.exp_id = i; v.exp_busy = b;
        v.exp_pend = pd; v.exp_drop = dr;
        return v;
    endfunction

    initial begin
        int busy_cnt;
        int n3;
        int npre;
        logic [N-1:0] r;
        logic e;

        req = '0; en = 1'b0; clr = 1'b0; rst = 1'b1;

        // Single event on requester 1: pulse two cycles later, busy for GAP cycles.
        tbl[0]  = mk(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
        tbl[1]  = mk(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000);
        tbl[2]  = mk(4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0000);
        for (int i = 3; i <= 9; i++)
            tbl[i] = mk(4'b0000, 1'b1, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000);
        tbl[10] = mk(4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000);
        tbl[11] = mk(4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            check("tbl_pulse", int'(pulse), int'(tbl[i].exp_pulse));
            check("tbl_id",    int'(id),    int'(tbl[i].exp_id));
            check("tbl_busy",  int'(busy),  int'(tbl[i].exp_busy));
            check("tbl_pend",  int'(pend),  int'(tbl[i].exp_pend));
            check("tbl_drop",  int'(drop),  int'(tbl[i].exp_drop));
            cycle(tbl[i].req, tbl[i].en, tbl[i].clr, 1'b0);
        end

        // All four requesters at once: round-robin pulses GAP apart.
        do_reset();
        pc.delete(); pid.delete();
        busy_cnt = 0;
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 36; c++) begin
            if (pulse) begin pc.push_back(c); pid.push_back(int'(id)); end
            if (busy) busy_cnt++;
            if (c == 1 || c >= 34) check("all_busy_off", int'(busy), 0);
            cycle('0, 1'b1, 1'b0, 1'b0);
        end
        check("all_npulse", pc.size(), 4);
        for (int k = 0; k < 4 && k < pc.size(); k++) begin
            check("all_pulse_cyc", pc[k], 2 + GAP * k);
            check("all_pulse_id",  pid[k], k);
        end
        check("all_busy_len", busy_cnt, 32);

        // Overflow on requester 3, then clear racing a new drop.
        do_reset();
        n3 = 0;
        for (int c = 0; c < 30; c++) begin
            r = (c == 0) ? 4'b1001 : (c == 5) ? 4'b1000 : 4'b0000;
            if (c == 5) check("ovf_drop_before", int'(drop), 0);
            if (c == 6) check("ovf_drop_after",  int'(drop), 4'b1000);
            if (pulse && id == 2'd3) n3++;
            cycle(r, 1'b1, 1'b0, 1'b0);
        end
        check("ovf_id3_pulses", n3, 1);
        cycle(4'b1000, 1'b0, 1'b0, 1'b0);
        cycle(4'b1000, 1'b0, 1'b1, 1'b0);
        check("ovf_clr_race", int'(drop), 4'b1000);
        cycle('0, 1'b0, 1'b1, 1'b0);
        check("ovf_clr", int'(drop), 0);

        // Re-request on the grant cycle is kept as a new event.
        do_reset();
        cycle(4'b0010, 1'b1, 1'b0, 1'b0);
        check("col_pend1", int'(pend), 4'b0010);
        cycle(4'b0010, 1'b1, 1'b0, 1'b0);
        check("col_pulse", int'(pulse), 1);
        check("col_pend2", int'(pend), 4'b0010);
        npre = 0;
        for (int c = 2; c <= 11; c++) begin
            if (c > 2 && c < 10 && pulse) npre++;
            if (c == 10) begin
                check("col_pulse2", int'(pulse), 1);
                check("col_id2",    int'(id),    1);
                check("col_drop",   int'(drop),  0);
            end
            cycle('0, 1'b1, 1'b0, 1'b0);
        end
        check("col_early_pulse", npre, 0);

        // Enable gating and full gap after enable drops.
        do_reset();
        pc.delete(); pid.delete();
        for (int c = 0; c <= 22; c++) begin
            e = (c >= 4 && c < 15);
            r = (c == 0) ? 4'b1001 : 4'b0000;
            if (pulse) begin pc.push_back(c); pid.push_back(int'(id)); end
            if (c == 4) begin
                check("en_pend_held", int'(pend), 4'b1001);
                check("en_no_pulse",  pc.size(),  0);
            end
            if (c == 20) check("en_busy_end", int'(busy), 1);
            if (c == 21) check("en_busy_off", int'(busy), 0);
            cycle(r, e, 1'b0, 1'b0);
        end
        check("en_npulse", pc.size(), 2);
        if (pc.size() == 2) begin
            check("en_p0_cyc", pc[0], 5);
            check("en_p0_id",  pid[0], 0);
            check("en_p1_cyc", pc[1], 13);
            check("en_p1_id",  pid[1], 3);
        end

        // Reset in the middle of a gap with two events pending.
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            r = (c == 0) ? 4'b0111 : (c == 6) ? 4'b0100 : 4'b0000;
            if (c == 5) begin
                check("rst_pre_pend", int'(pend), 4'b0110);
                check("rst_pre_busy", int'(busy), 1);
            end
            if (c == 6) begin
                check("rst_pulse", int'(pulse), 0);
                check("rst_id",    int'(id),    0);
                check("rst_busy",  int'(busy),  0);
                check("rst_pend",  int'(pend),  0);
                check("rst_drop",  int'(drop),  0);
            end
            if (c == 8) begin
                check("rst_new_pulse", int'(pulse), 1);
                check("rst_new_id",    int'(id),    2);
            end
            cycle(r, 1'b1, 1'b0, c == 5);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            check_vs_model();
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 9) == 0);
            cycle(r, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_event_scheduler.md
Name: cdc_event_scheduler

Overview:
- Source-domain controller that shares one toggle-synchronizer CDC channel among N_REQ event requesters.
- Captures single-cycle event pulses per requester and grants them round-robin.
- Emits at most one pulse to the synchronizer every GAP_CYCLES cycles, so the slow destination domain resolves every event.
- Drives an event ID that stays stable alongside each pulse; records and flags dropped events.

Parameters:
- N_REQ, 4: number of requesters; range 2..16.
- GAP_CYCLES, 32: minimum source-clock cycles between consecutive pulse_o assertions (rising edge to rising edge). Range 2..255. Size to at least 3 destination cycles.
- ID_W, $clog2(N_REQ): width of id_o.

Ports:
- clk_i  in  1  source-domain clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  per-requester event pulses, one bit per requester.
- en_i  in  1  grant enable; low suppresses new grants.
- clr_drop_i  in  1  clears drop_o.
- pulse_o  out  1  one-cycle pulse to the toggle synchronizer input.
- id_o  out  ID_W  ID of the last granted requester.
- busy_o  out  1  channel occupied (pulse or guard gap in progress).
- pending_o  out  N_REQ  captured, not yet granted events.
- drop_o  out  N_REQ  sticky per-requester overflow flags.

Behaviour:
- Reset: rst_i is sampled on rising clk_i. Reset values:
  - pulse_o=0, id_o=0, busy_o=0, pending_o=0, drop_o=0.
  - FSM in IDLE, gap counter 0.
  - Round-robin pointer set so requester 0 is searched first.
- Reset mid-gap or with events pending: all state clears, no pulse is emitted, and captured events are discarded.
- Capture:
  - req_i[i] high at edge k sets pending[i], visible from cycle k+1.
  - req_i[i] while pending[i] is already set: the event is lost and drop_o[i] is set.
  - req_i[i] in the same cycle that pending[i] is cleared by grant: pending[i] stays set (new event), no drop.
- drop_o: sticky. clr_drop_i clears all bits. A new drop in the same cycle as clr_drop_i wins (bit set).
- FSM states: IDLE, GAP.
- IDLE:
  - Grant occurs if en_i=1 and pending != 0.
  - The winner is the first set bit searching from (last_grant+1) mod N_REQ upward with wrap-around.
  - On grant, registered outputs next cycle: pulse_o=1 (exactly one cycle), id_o=winner, busy_o=1, pending[winner] cleared.
  - FSM goes to GAP.
- GAP:
  - pulse_o=0, busy_o=1, id_o held.
  - After GAP_CYCLES total cycles of busy_o high (counting the pulse cycle), the FSM returns to IDLE.
  - A new grant is allowed in that return cycle, so back-to-back pulses are exactly GAP_CYCLES apart and busy_o stays continuously high.
- Latency:
  - Event at cycle 0 with the channel idle -> pulse_o in cycle 2.
  - id_o is valid in the pulse cycle and remains stable until the next pulse.
- en_i low:
  - No new grants; pending keeps accumulating.
  - A gap already in progress completes normally.
  - Deasserting en_i during GAP does not truncate the gap.
- Fairness: with all requesters continuously pending, grants cycle 0,1,..,N_REQ-1,0,... No requester waits more than N_REQ grants.
- Invariants:
  - pulse_o never high on two cycles less than GAP_CYCLES apart.
  - pulse_o implies busy_o.
  - id_o changes only in pulse cycles.

Test Plan (N_REQ=4, GAP_CYCLES=8):
- Reset then single event: req_i=4'b0010 at cycle 0 -> pulse_o=1 at cycle 2, id_o=1; busy_o high cycles 2..9; pending_o=0 from cycle 2.
- All four requesters pulse at cycle 0 -> pulses at cycles 2,10,18,26 with id_o 0,1,2,3; busy_o continuously high cycles 2..33.
- Overflow: req_i[3] at cycles 0 and 5 while req_i[0] is pending ahead of it -> drop_o[3]=1 from cycle 6; only one id 3 pulse. clr_drop_i plus a new drop in the same cycle -> drop_o[3] stays 1.
- Grant/request collision: req_i[1] re-pulses in the cycle pending[1] is granted -> pending_o[1] remains 1; second id 1 pulse after the gap; drop_o[1]=0.
- en_i=0 while req_i=4'b1001 -> no pulse, pending_o=4'b1001. Raise en_i -> pulses id 0 then id 3, 8 cycles apart. Drop en_i mid-gap -> busy_o still lasts the full 8 cycles.
- rst_i asserted 3 cycles into a gap with 2 pending -> next cycle all outputs 0. After release, a new req_i[2] event -> pulse 2 cycles later, id_o=2.
